// File: rtl/concat_requant_scale_if.sv
// Stream bundle for concat_requant_scale: input beat with valid/ready and
// the requantised output beat with its saturation flags.
// Ports carried:
//   In_Valid/In_Ready, Concat_Data_In, Scale_Data_In, Shift_In,
//   Zero_Point_In, Bypass_In  (input beat)
//   Out_Valid/Out_Ready, Scale_Data_Out, Sat_Flag_Out  (output beat)
// master = the side around the block, slave = concat_requant_scale itself.
// Instantiate with the same parameters as the block it connects to.
interface concat_requant_scale_if #(
    parameter int PIC_NUM = 2,
    parameter int CH_NUM  = 16,
    parameter int DATA_W  = 32,
    parameter int SCALE_W = 32,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 32
) ();
    localparam int LANES = PIC_NUM * CH_NUM;

    logic                     In_Valid;
    logic                     In_Ready;
    logic [LANES*DATA_W-1:0]  Concat_Data_In;
    logic [SCALE_W-1:0]       Scale_Data_In;
    logic [SHIFT_W-1:0]       Shift_In;
    logic [OUT_W-1:0]         Zero_Point_In;
    logic                     Bypass_In;
    logic                     Out_Valid;
    logic                     Out_Ready;
    logic [LANES*OUT_W-1:0]   Scale_Data_Out;
    logic [LANES-1:0]         Sat_Flag_Out;

    modport master (
        output In_Valid, Concat_Data_In, Scale_Data_In, Shift_In,
        output Zero_Point_In, Bypass_In, Out_Ready,
        input  In_Ready, Out_Valid, Scale_Data_Out, Sat_Flag_Out
    );

    modport slave (
        input  In_Valid, Concat_Data_In, Scale_Data_In, Shift_In,
        input  Zero_Point_In, Bypass_In, Out_Ready,
        output In_Ready, Out_Valid, Scale_Data_Out, Sat_Flag_Out
    );
endinterface

// File: rtl/concat_requant_scale.sv
// Concat-path requantiser: per-lane A*S, round-half-up shift, zero-point add,
// unsigned saturation; 4-stage pipeline with full valid/ready back-pressure.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : concat_requant_scale_if.slave (input beat, output beat)
// Lane k = ch*PIC_NUM+pic lives at bits [k*W +: W] on both data buses.
module concat_requant_scale #(
    parameter int PIC_NUM = 2,
    parameter int CH_NUM  = 16,
    parameter int DATA_W  = 32,
    parameter int SCALE_W = 32,
    parameter int SHIFT_W = 6,
    parameter int OUT_W   = 32
) (
    input logic clk,
    input logic rst,
    concat_requant_scale_if.slave bus
);
    localparam int LANES = PIC_NUM * CH_NUM;
    localparam int PW    = DATA_W + SCALE_W;
    // one extra bit so the rounding carry is never lost
    localparam int RW    = PW + 1;
    localparam int TW    = ((RW > OUT_W) ? RW : OUT_W) + 1;

    logic adv;
    logic v1, v2, v3, v4;

    // S1: captured beat
    logic [DATA_W-1:0]  a1 [LANES];
    logic [SCALE_W-1:0] s1;
    logic [SHIFT_W-1:0] sh1;
    logic [OUT_W-1:0]   zp1;
    logic               bp1;

    // S2: full-width products
    logic [PW-1:0]      p2 [LANES];
    logic [DATA_W-1:0]  a2 [LANES];
    logic [SHIFT_W-1:0] sh2;
    logic [OUT_W-1:0]   zp2;
    logic               bp2;

    // S3: rounded and shifted
    logic [RW-1:0]      r3 [LANES];
    logic [DATA_W-1:0]  a3 [LANES];
    logic [OUT_W-1:0]   zp3;
    logic               bp3;

    // S4: output registers
    logic [LANES*OUT_W-1:0] data_q;
    logic [LANES-1:0]       sat_q;

    logic [RW-1:0]    rnd;
    logic [RW-1:0]    r_d [LANES];
    logic [TW-1:0]    t_d [LANES];
    logic [OUT_W-1:0] o_d [LANES];
    logic [LANES-1:0] sat_d;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign adv          = !v4 || bus.Out_Ready;
    assign bus.In_Ready = adv && !rst;

    assign bus.Out_Valid      = v4;
    assign bus.Scale_Data_Out = data_q;
    assign bus.Sat_Flag_Out   = sat_q;

    // Half of the dropped LSB weight; zero when nothing is shifted out.
    always_comb begin
        rnd = '0;
        if (sh2 != '0) begin
            rnd = RW'(1) << (sh2 - SHIFT_W'(1));
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            r_d[k] = (RW'(p2[k]) + rnd) >> sh2;
        end
    end

    always_comb begin
        sat_d = '0;
        for (int k = 0; k < LANES; k++) begin
            t_d[k] = TW'(r3[k]) + TW'(zp3);
            o_d[k] = t_d[k][OUT_W-1:0];
            if (bp3) begin
                o_d[k] = OUT_W'(a3[k]);
            end else if (|t_d[k][TW-1:OUT_W]) begin
                o_d[k]   = '1;
                sat_d[k] = 1'b1;
            end
        end
    end

    // Data path without reset so the multiplier packs into DSP registers;
    // garbage in empty stages is masked by the valid bits.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < LANES; k++) begin
                a1[k] <= bus.Concat_Data_In[k*DATA_W +: DATA_W];
                p2[k] <= PW'(a1[k]) * PW'(s1);
                a2[k] <= a1[k];
                r3[k] <= r_d[k];
                a3[k] <= a2[k];
            end
            s1  <= bus.Scale_Data_In;
            sh1 <= bus.Shift_In;
            zp1 <= bus.Zero_Point_In;
            bp1 <= bus.Bypass_In;
            sh2 <= sh1;
            zp2 <= zp1;
            bp2 <= bp1;
            zp3 <= zp2;
            bp3 <= bp2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v3     <= 1'b0;
            v4     <= 1'b0;
            data_q <= '0;
            sat_q  <= '0;
        end else if (adv) begin
            v1 <= bus.In_Valid;
            v2 <= v1;
            v3 <= v2;
            v4 <= v3;
            for (int k = 0; k < LANES; k++) begin
                data_q[k*OUT_W +: OUT_W] <= o_d[k];
            end
            sat_q <= sat_d;
        end
    end
endmodule
